// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store memory-access stage (optional REQ timeout: LSU_TIMEOUT_EN)
module load_store_unit #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         is_store_i,
    input  logic [2:0]   funct3_i,
    input  logic [N-1:0] addr_i,
    input  logic [N-1:0] wdata_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         fault_o,
    output logic [N-1:0] rdata_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [N-1:0] mem_addr_o,
    output logic [3:0]   mem_be_o,
    output logic [N-1:0] mem_wdata_o,
    input  logic         mem_ready_i,
    input  logic [N-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         fault_q, fault_d;
    logic         we_q, we_d;
    logic [2:0]   f3_q, f3_d;
    logic [1:0]   off_q, off_d;
    logic [N-1:0] addr_q, addr_d;
    logic [3:0]   be_q, be_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] rdata_q, rdata_d;
`ifdef LSU_TIMEOUT_EN
    logic [7:0]   cnt_q, cnt_d;
`endif

    logic         req_legal;
    logic         req_aligned;
    logic [3:0]   req_be;
    logic [N-1:0] req_wdata;
    logic [N-1:0] lane;
    logic [N-1:0] load_ext;

    // Decode the incoming request: legality, alignment, byte enables, replicated store data
    always_comb begin
        req_legal   = 1'b0;
        req_aligned = 1'b1;
        req_be      = 4'b1111;
        req_wdata   = wdata_i;
        if (is_store_i) begin
            req_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
        end else begin
            req_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                        (funct3_i == 3'b100) || (funct3_i == 3'b101);
        end
        case (funct3_i[1:0])
            2'b00: begin
                req_be    = 4'b0001 << addr_i[1:0];
                req_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                req_aligned = ~addr_i[0];
                req_be      = 4'b0011 << {addr_i[1], 1'b0};
                req_wdata   = {2{wdata_i[15:0]}};
            end
            default: begin
                req_aligned = (addr_i[1:0] == 2'b00);
                req_be      = 4'b1111;
                req_wdata   = wdata_i;
            end
        endcase
    end

    // Steer the addressed lane down to bit 0 and sign/zero extend it
    always_comb begin
        lane = mem_rdata_i >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{(N-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(N-16){lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {{(N-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(N-16){1'b0}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Next-state logic: request capture in IDLE, transfer/timeout in REQ, single-cycle DONE
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (req_legal && req_aligned) begin
                        state_d = ST_REQ;
                        fault_d = 1'b0;
                        we_d    = is_store_i;
                        f3_d    = funct3_i;
                        off_d   = addr_i[1:0];
                        addr_d  = {addr_i[N-1:2], 2'b00};
                        be_d    = req_be;
                        wdata_d = req_wdata;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end else begin
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready_i) begin
                    state_d = ST_DONE;
                    fault_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = load_ext;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == 8'hFF) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any access in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            fault_q <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign fault_o     = done_o & fault_q;
    assign mem_req_o   = (state_q == ST_REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard testbench for load_store_unit
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    logic [31:0] last_rdata = 32'h0;

    load_store_unit #(.N(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .is_store_i  (is_store),
        .funct3_i    (funct3),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .busy_o      (busy),
        .done_o      (done),
        .fault_o     (fault),
        .rdata_o     (rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_ready_i (mem_ready),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = (off <= 2) ? w[8*off +: 16] : 16'h0;
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input int off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {w[7:0], w[7:0], w[7:0], w[7:0]};
            2'b01:   return {w[15:0], w[15:0]};
            default: return w;
        endcase
    endfunction

    // Drives start for one cycle (cycle 0); returns at the negedge of cycle 1
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        start    = 1'b1;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        @(negedge clk);
        start    = 1'b0;
        is_store = 1'b0;
        funct3   = 3'b000;
        addr     = 32'h0;
        wdata    = 32'h0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({busy, done, fault, mem_req, mem_we} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {busy, done, fault, mem_req, mem_we});
        end
        total++; if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
            bad++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h be=%b want all 0", rdata, mem_addr, mem_wdata, mem_be);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lb;
        exp_t e;
        issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        sb_q.push_back('{fault: 1'b0, rdata: 32'hFFFF_FF80});
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL lb_cycle1 got req=%b we=%b busy=%b done=%b want 1 0 1 0", mem_req, mem_we, busy, done);
        end
        total++; if (mem_addr !== 32'h0000_1000 || mem_be !== 4'b1000) begin
            bad++; $display("FAIL lb_addr_be got addr=%h be=%b want 00001000 1000", mem_addr, mem_be);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h80FF_0000;
        @(negedge clk);
        mem_ready = 1'b0;
        total++; if (done !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL lb_done got done=%b req=%b want 1 0", done, mem_req);
        end
        e = sb_q.pop_front();
        total++; if (fault !== e.fault || rdata !== e.rdata) begin
            bad++; $display("FAIL lb_result got fault=%b rdata=%h want %b %h", fault, rdata, e.fault, e.rdata);
        end
        last_rdata = e.rdata;
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL lb_idle got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_lhu_wait;
        exp_t e;
        issue(1'b0, 3'b101, 32'h0000_2002, 32'h0);
        sb_q.push_back('{fault: 1'b0, rdata: 32'h0000_BEEF});
        for (int c = 1; c <= 4; c++) begin
            total++; if (mem_req !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL lhu_wait_c%0d got req=%b done=%b want 1 0", c, mem_req, done);
            end
            if (c == 2) start = 1'b1;
            if (c == 2) addr = 32'h0000_5000;
            if (c == 3) start = 1'b0;
            if (c == 4) begin
                total++; if (mem_addr !== 32'h0000_2000 || mem_be !== 4'b1100) begin
                    bad++; $display("FAIL lhu_hold got addr=%h be=%b want 00002000 1100", mem_addr, mem_be);
                end
                mem_ready = 1'b1;
                mem_rdata = 32'hBEEF_1234;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        addr = 32'h0;
        total++; if (done !== 1'b1) begin
            bad++; $display("FAIL lhu_done got done=%b want 1", done);
        end
        e = sb_q.pop_front();
        total++; if (fault !== e.fault || rdata !== e.rdata) begin
            bad++; $display("FAIL lhu_result got fault=%b rdata=%h want %b %h", fault, rdata, e.fault, e.rdata);
        end
        last_rdata = e.rdata;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL lhu_drop got busy=%b want 0", busy);
        end
    endtask

    task automatic test_sb;
        exp_t e;
        issue(1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB);
        sb_q.push_back('{fault: 1'b0, rdata: last_rdata});
        total++; if (mem_we !== 1'b1 || mem_be !== 4'b0010 || mem_wdata !== 32'hABAB_ABAB || mem_addr !== 32'h0000_3000) begin
            bad++; $display("FAIL sb_fields got we=%b be=%b wdata=%h addr=%h want 1 0010 abababab 00003000", mem_we, mem_be, mem_wdata, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ready = 1'b0;
        e = sb_q.pop_front();
        total++; if (done !== 1'b1 || fault !== e.fault || rdata !== e.rdata) begin
            bad++; $display("FAIL sb_result got done=%b fault=%b rdata=%h want 1 %b %h", done, fault, rdata, e.fault, e.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_faults;
        logic        st_t[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3_t[5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
        logic [31:0] ad_t[5] = '{32'h3001, 32'h3000, 32'h3002, 32'h3000, 32'h3000};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(st_t[i], f3_t[i], ad_t[i], 32'hFFFF_FFFF);
            sb_q.push_back('{fault: 1'b1, rdata: last_rdata});
            e = sb_q.pop_front();
            total++; if (done !== 1'b1 || fault !== e.fault || mem_req !== 1'b0 || rdata !== e.rdata) begin
                bad++; $display("FAIL fault_%0d got done=%b fault=%b req=%b rdata=%h want 1 %b 0 %h", i, done, fault, mem_req, rdata, e.fault, e.rdata);
            end
            @(negedge clk);
            total++; if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
                bad++; $display("FAIL fault_end_%0d got done=%b busy=%b req=%b want 0 0 0", i, done, busy, mem_req);
            end
        end
    endtask

    task automatic test_rst_mid;
        exp_t e;
        int   seen;
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_async got req=%b busy=%b want 0 0", mem_req, busy);
        end
        #1 rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen != 0) begin
            bad++; $display("FAIL rst_no_done got done_cycles=%0d want 0", seen);
        end
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        sb_q.push_back('{fault: 1'b0, rdata: 32'hDEAD_BEEF});
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ready = 1'b0;
        e = sb_q.pop_front();
        total++; if (done !== 1'b1 || fault !== e.fault || rdata !== e.rdata) begin
            bad++; $display("FAIL rst_recover got done=%b fault=%b rdata=%h want 1 %b %h", done, fault, rdata, e.fault, e.rdata);
        end
        last_rdata = e.rdata;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int cyc;
        exp_t e;
        issue(1'b0, 3'b010, 32'h0000_0080, 32'h0);
        mem_ready = 1'b0;
`ifdef LSU_TIMEOUT_EN
        sb_q.push_back('{fault: 1'b1, rdata: last_rdata});
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        total++; if (cyc != 257) begin
            bad++; $display("FAIL timeout_cycle got done_cycle=%0d want 257", cyc);
        end
        total++; if (done !== 1'b1 || fault !== e.fault || mem_req !== 1'b0 || rdata !== e.rdata) begin
            bad++; $display("FAIL timeout_result got done=%b fault=%b req=%b rdata=%h want 1 1 0 %h", done, fault, mem_req, rdata, e.rdata);
        end
        @(negedge clk);
`else
        cyc = 1;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (busy !== 1'b1 || mem_req !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL no_timeout got busy=%b req=%b done=%b at cycle %0d want 1 1 0 at 1000", busy, mem_req, done, cyc);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rdata = 32'h0;
        @(negedge clk);
`endif
    endtask

    task automatic test_back_to_back;
        logic        st_t[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3_t[8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b010, 3'b001};
        int          of_t[8] = '{2, 1, 2, 0, 0, 2, 0, 0};
        logic [31:0] word;
        logic [31:0] wd;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            word = $urandom();
            wd   = $urandom();
            issue(st_t[i], f3_t[i], 32'h0000_0100 + of_t[i], wd);
            if (!st_t[i]) last_rdata = model_load(f3_t[i], of_t[i], word);
            sb_q.push_back('{fault: 1'b0, rdata: last_rdata});
            total++; if (mem_req !== 1'b1 || mem_we !== st_t[i] || mem_be !== model_be(f3_t[i], of_t[i])) begin
                bad++; $display("FAIL b2b_req_%0d got req=%b we=%b be=%b want 1 %b %b", i, mem_req, mem_we, mem_be, st_t[i], model_be(f3_t[i], of_t[i]));
            end
            if (st_t[i]) begin
                total++; if (mem_wdata !== model_wdata(f3_t[i], wd)) begin
                    bad++; $display("FAIL b2b_wdata_%0d got %h want %h", i, mem_wdata, model_wdata(f3_t[i], wd));
                end
            end
            mem_ready = 1'b1;
            mem_rdata = word;
            @(negedge clk);
            mem_ready = 1'b0;
            e = sb_q.pop_front();
            total++; if (done !== 1'b1 || fault !== e.fault || rdata !== e.rdata) begin
                bad++; $display("FAIL b2b_result_%0d got done=%b fault=%b rdata=%h want 1 %b %h", i, done, fault, rdata, e.fault, e.rdata);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        is_store  = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        test_reset();
        test_lb();
        test_lhu_wait();
        test_sb();
        test_faults();
        test_rst_mid();
        test_timeout();
        test_back_to_back();
        total++; if (sb_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover got %0d entries want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
